mdu_iterative: RTL and testbench

Iterative RV32M multiply/divide unit for the RISC-V core. It consumes the two register-file read operands (RD1/RD2) for an M-extension instruction, runs a fixed 32-iteration shift-add / restoring-divide datapath, and produces a one-cycle writeback (`we_out`, `rd_out`, `result`) that drives the register-file write port (WE3/A3/WD3). The core stalls on `busy`.

---
 rtl/mdu_iterative.sv | 166 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide sharing one accumulator, with a registered one-cycle writeback pulse.
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            we_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic   launch, last;

    logic [4:0]      cnt;
    logic [2:0]      fn;
    logic [4:0]      rd_q;
    logic            neg_a, neg_b, b_zero;
    logic [XLEN-1:0] hi, lo, opnd;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    state_nxt = S_RUN;
                    launch    = 1'b1;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 5'd31) begin
                    state_nxt = S_DONE;
                    last      = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand signedness at launch; MUL's low word is sign-agnostic, so it runs unsigned.
    logic            signed_a_in, signed_b_in;
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        signed_a_in = 1'b0;
        signed_b_in = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                signed_a_in = 1'b1;
                signed_b_in = 1'b1;
            end
            3'b010:  signed_a_in = 1'b1;
            default: ;
        endcase
    end

    assign neg_a_in = signed_a_in & op_a[XLEN-1];
    assign neg_b_in = signed_b_in & op_b[XLEN-1];
    assign mag_a    = neg_a_in ? -op_a : op_a;
    assign mag_b    = neg_b_in ? -op_b : op_b;

    // One iteration: hi/lo hold product-high/multiplier or remainder/quotient.
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum, shifted, diff;
    logic [XLEN-1:0] hi_nxt, lo_nxt;

    always_comb begin
        addend  = lo[0] ? opnd : '0;
        sum     = {1'b0, hi} + {1'b0, addend};
        shifted = {hi, lo[XLEN-1]};
        // hi < divisor keeps the trial difference inside XLEN+1 signed bits.
        diff    = shifted - {1'b0, opnd};
        if (fn[2]) begin
            hi_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = b_zero ? '1 : ((neg_a ^ neg_b) ? -lo_nxt : lo_nxt);
        rem_fix  = neg_a ? -hi_nxt : hi_nxt;
        case (fn)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // NOTE: the iteration datapath carries no reset; launch reloads it before any
    // value is consumed, and only visible outputs need defined reset values.
    always_ff @(posedge clk) begin
        if (launch) begin
            hi     <= '0;
            lo     <= mag_a;
            opnd   <= mag_b;
            fn     <= funct3;
            rd_q   <= rd_in;
            neg_a  <= neg_a_in;
            neg_b  <= neg_b_in;
            b_zero <= (op_b == '0);
        end else if (state == S_RUN) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

    // rd_out and result only move on completion, so a flush leaves them intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 5'd0;
            rd_out <= 5'd0;
            result <= '0;
        end else begin
            if (launch)                cnt <= 5'd0;
            else if (state == S_RUN)   cnt <= cnt + 5'd1;
            if (last) begin
                result <= final_res;
                rd_out <= rd_q;
            end
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign we_out = done;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, we_out;
    logic [4:0]  rd_out;
    logic [31:0] result;

    mdu_iterative #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .we_out (we_out),
        .rd_out (rd_out),
        .result (result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    always @(posedge clk) if (done) done_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit / 32-bit arithmetic on the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        int          ai, bi;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        ai = a;
        bi = b;
        sa = ai;
        sb = bi;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ai / bi);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ai % bi);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Presents one start edge (E0); returns at the falling edge just after E0.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
        rd_in  = 5'($urandom);
    endtask

    // Waits (bounded) for done, then checks latency, writeback and the one-cycle pulse.
    task automatic finish_op(input string tag, input logic [31:0] exp, input logic [4:0] rd);
        int n;
        n = 0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 32'd32);
        check({tag, " result"}, result, exp);
        check({tag, " we_out"}, 32'(we_out), 32'd1);
        check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
        @(negedge clk);
        check({tag, " done_drop"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] r1, r2, saved_res;
        logic [4:0]  saved_rd;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          n, first_at, second_at, d0;

        vecs.push_back('{"mul_7x-3",      3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB});
        vecs.push_back('{"mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000});
        vecs.push_back('{"mulhu_max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE});
        vecs.push_back('{"mulhsu_max",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF});
        vecs.push_back('{"div_-7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD});
        vecs.push_back('{"rem_-7/2",      3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF});
        vecs.push_back('{"divu_100/0",    3'd5, 32'd100,        32'd0,         5'd11, 32'hFFFF_FFFF});
        vecs.push_back('{"remu_100/0",    3'd7, 32'd100,        32'd0,         5'd12, 32'd100});
        vecs.push_back('{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000});
        vecs.push_back('{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0});
        vecs.push_back('{"div_-7/0",      3'd4, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFFF});
        vecs.push_back('{"rem_-7/0",      3'd6, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9});
        vecs.push_back('{"mul_rd0",       3'd0, 32'd9,          32'd9,         5'd0,  32'd81});
        vecs.push_back('{"divu_big",      3'd5, 32'hFFFF_FFFF,  32'd3,         5'd31, 32'h5555_5555});

        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        rd_in  = 5'd0;
        repeat (3) @(negedge clk);
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset we_out", 32'(we_out), 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        check("reset result", result,      32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            launch(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
            finish_op(vecs[i].name, vecs[i].exp, vecs[i].rd);
        end

        // start held high through a whole operation: taken once back in IDLE.
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd1; start = 1'b1;
        @(negedge clk);
        op_a = 32'd6; op_b = 32'd7; rd_in = 5'd2;
        d0 = done_seen; n = 0; first_at = -1; second_at = -1; r1 = '0; r2 = '0;
        while (n < 75) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (first_at < 0) begin first_at = n; r1 = result; end
                else if (second_at < 0) begin second_at = n; r2 = result; end
            end
            if (n == 34) start = 1'b0;
        end
        check("held first_at",  first_at,  32'd32);
        check("held second_at", second_at, 32'd66);
        check("held r1", r1, 32'd15);
        check("held r2", r2, 32'd42);
        check("held done_count", done_seen - d0, 32'd2);

        // Flush mid-run: no done, result/rd_out untouched.
        saved_res = result;
        saved_rd  = rd_out;
        d0 = done_seen;
        launch(3'd5, 32'd1000, 32'd7, 5'd20);
        for (int k = 0; k < 10; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush idle", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush no_done", done_seen - d0, 32'd0);
        check("flush result", result, saved_res);
        check("flush rd_out", 32'(rd_out), 32'(saved_rd));
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start idle", 32'(busy), 32'd0);
        launch(3'd5, 32'd1000, 32'd7, 5'd21);
        finish_op("after_flush", 32'd142, 5'd21);

        // Reset during a divide.
        d0 = done_seen;
        launch(3'd4, 32'hFFFF_0000, 32'd3, 5'd22);
        for (int k = 0; k < 14; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid busy",   32'(busy),   32'd0);
        check("rst_mid done",   32'(done),   32'd0);
        check("rst_mid we_out", 32'(we_out), 32'd0);
        check("rst_mid rd_out", 32'(rd_out), 32'd0);
        check("rst_mid result", result,      32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_mid no_done", done_seen - d0, 32'd0);
        launch(3'd0, 32'd3, 32'd4, 5'd3);
        finish_op("after_rst", 32'd12, 5'd3);

        // Randomized operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                3: b = $urandom_range(1, 5);
                default: ;
            endcase
            launch(f, a, b, 5'(k));
            finish_op($sformatf("rand%0d f%0d", k, f), model(f, a, b), 5'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
